// File: rtl/pal_sched_pkg.sv
// Shared state encoding, default timing constants and a width helper for the
// PAL line scheduler.
package pal_sched_pkg;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        ARM_A = 2'd1,
        ARM_B = 2'd2,
        PAD   = 2'd3
    } sched_state_t;

    localparam int DEF_LINE_CLKS   = 912;
    localparam int DEF_HS_CLKS     = 67;
    localparam int DEF_PAD_A_LINES = 25;
    localparam int DEF_PAD_B_LINES = 25;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Active-low sync edge detector. With PAL_SCHED_SYNC_EN defined the input first
// passes a 2-flop synchroniser; otherwise it is treated as synchronous to clk.
module sync_edge_det
    import pal_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic prev;

`ifdef PAL_SCHED_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], din};
    end

    assign level = sync[1];
`else
    assign level = din;
`endif

    // Reset to the idle (high) level so a held-high input never reads as an edge.
    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= level;
    end

    assign rise = ~prev & level;
    assign fall = prev & ~level;

endmodule

// File: rtl/pal_line_scheduler.sv
// Freezes the VDG and synthesises blank-line hsync to stretch a 262-line field
// to 312 lines. Build option PAL_SCHED_SYNC_EN adds input synchronisers.
//
// state | meaning
// PASS  | VDG runs, hs_out follows sampled hs_n
// ARM_A | fs_n fell, waiting for next hs_n fall to start block A
// ARM_B | fs_n rose, waiting for next hs_n fall to start block B
// PAD   | VDG frozen, generating pad_target blank lines
module pal_line_scheduler
    import pal_sched_pkg::*;
#(
    parameter int LINE_CLKS   = DEF_LINE_CLKS,
    parameter int HS_CLKS     = DEF_HS_CLKS,
    parameter int PAD_A_LINES = DEF_PAD_A_LINES,
    parameter int PAD_B_LINES = DEF_PAD_B_LINES
) (
    input  logic clk,
    input  logic rst,
    input  logic pal_en,
    input  logic hs_n,
    input  logic fs_n,
    output logic vdg_clk_en,
    output logic hs_out,
    output logic pad_active
);

    localparam int LW = cnt_width(LINE_CLKS - 1);
    localparam int PW = cnt_width((PAD_A_LINES > PAD_B_LINES) ? PAD_A_LINES : PAD_B_LINES);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINE_CLKS - 1);
    localparam logic [LW-1:0] HS_END    = LW'(HS_CLKS);
    localparam logic [PW-1:0] TGT_A     = PW'(PAD_A_LINES);
    localparam logic [PW-1:0] TGT_B     = PW'(PAD_B_LINES);
    localparam logic          A_EN      = 1'(PAD_A_LINES > 0);
    localparam logic          B_EN      = 1'(PAD_B_LINES > 0);

    sched_state_t  state, state_nxt;
    logic [LW-1:0] line_cnt, line_nxt;
    logic [PW-1:0] pad_cnt, pad_nxt, pad_target, target_nxt;
    logic          pend_a, pend_a_nxt, pend_b, pend_b_nxt, b_first, b_first_nxt;
    logic          hs_out_nxt;
    logic          hs_level, hs_fall, hs_rise_unused;
    logic          fs_level_unused, fs_rise, fs_fall;

    sync_edge_det u_hs_det (
        .clk   (clk),
        .rst   (rst),
        .din   (hs_n),
        .level (hs_level),
        .rise  (hs_rise_unused),
        .fall  (hs_fall)
    );

    sync_edge_det u_fs_det (
        .clk   (clk),
        .rst   (rst),
        .din   (fs_n),
        .level (fs_level_unused),
        .rise  (fs_rise),
        .fall  (fs_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PASS;
            line_cnt   <= '0;
            pad_cnt    <= '0;
            pad_target <= '0;
            pend_a     <= 1'b0;
            pend_b     <= 1'b0;
            b_first    <= 1'b0;
            vdg_clk_en <= 1'b1;
            hs_out     <= 1'b1;
            pad_active <= 1'b0;
        end else begin
            state      <= state_nxt;
            line_cnt   <= line_nxt;
            pad_cnt    <= pad_nxt;
            pad_target <= target_nxt;
            pend_a     <= pend_a_nxt;
            pend_b     <= pend_b_nxt;
            b_first    <= b_first_nxt;
            vdg_clk_en <= (state_nxt != PAD);
            hs_out     <= hs_out_nxt;
            pad_active <= (state_nxt == PAD);
        end
    end

    always_comb begin
        state_nxt   = state;
        line_nxt    = line_cnt;
        pad_nxt     = pad_cnt;
        target_nxt  = pad_target;
        pend_a_nxt  = pend_a;
        pend_b_nxt  = pend_b;
        b_first_nxt = b_first;

        // b_first only matters when both flags are set: it records which came first.
        if (state != PASS) begin
            if (!pal_en) begin
                pend_a_nxt = 1'b0;
                pend_b_nxt = 1'b0;
            end else begin
                if (fs_fall && A_EN && !pend_a) begin
                    pend_a_nxt  = 1'b1;
                    b_first_nxt = pend_b;
                end
                if (fs_rise && B_EN && !pend_b) begin
                    pend_b_nxt  = 1'b1;
                    b_first_nxt = !pend_a;
                end
            end
        end

        case (state)
            PASS: begin
                if (pal_en) begin
                    if (fs_fall && A_EN)      state_nxt = ARM_A;
                    else if (fs_rise && B_EN) state_nxt = ARM_B;
                end
            end
            ARM_A, ARM_B: begin
                if (hs_fall) begin
                    state_nxt  = PAD;
                    target_nxt = (state == ARM_A) ? TGT_A : TGT_B;
                    line_nxt   = '0;
                    pad_nxt    = '0;
                end
            end
            PAD: begin
                if (line_cnt == LINE_LAST) begin
                    line_nxt = '0;
                    if (pad_cnt + PW'(1) == pad_target) begin
                        if (pend_a_nxt && (!pend_b_nxt || !b_first_nxt)) begin
                            state_nxt  = ARM_A;
                            pend_a_nxt = 1'b0;
                        end else if (pend_b_nxt) begin
                            state_nxt  = ARM_B;
                            pend_b_nxt = 1'b0;
                        end else begin
                            state_nxt  = PASS;
                        end
                    end else begin
                        pad_nxt = pad_cnt + PW'(1);
                    end
                end else begin
                    line_nxt = line_cnt + LW'(1);
                end
            end
            default: state_nxt = PASS;
        endcase

        hs_out_nxt = (state_nxt == PAD) ? (line_nxt >= HS_END) : hs_level;
    end

endmodule

// File: doc/pal_line_scheduler.md
# pal_line_scheduler

Sequences PAL line padding for the Dragon VDG path: holds the VDG clock enable low to insert two blocks of blank lines per field (25 after field-sync start, 25 after field-sync end), converting the 262-line NTSC field to 312 lines for 50 Hz output. While the VDG is frozen, it synthesises horizontal sync from its own line timer. Sits between the VDG timing outputs (HS, FS) and the VDG clock gate / video sync combiner.

## Interface
- LINE_CLKS, 912: clk cycles per line period; min 4.
- HS_CLKS, 67: clk cycles hs_out is held low per generated line; 1..LINE_CLKS-1.
- PAD_A_LINES, 25: lines inserted after fs_n falling edge; 0 disables.
- PAD_B_LINES, 25: lines inserted after fs_n rising edge; 0 disables.
- clk  in  1  master pixel-rate clock.
- rst  in  1  synchronous, active-high reset.
- pal_en  in  1  1 = padding active; 0 = pure pass-through (NTSC).
- hs_n  in  1  VDG horizontal sync, active low.
- fs_n  in  1  VDG field sync, active low.
- vdg_clk_en  out  1  VDG clock enable; 0 freezes VDG.
- hs_out  out  1  composite-path horizontal sync, active low.
- pad_active  out  1  high while padding lines are being generated.

## Operation
- States: PASS, ARM_A, ARM_B, PAD.
- Reset: state PASS, vdg_clk_en=1, hs_out=1, pad_active=0, counters 0, pending flags clear.
- PASS: hs_out follows sampled hs_n; vdg_clk_en=1. Detected fs_n fall with pal_en=1 and PAD_A_LINES>0 -> ARM_A. Detected fs_n rise with pal_en=1 and PAD_B_LINES>0 -> ARM_B.
- ARM_x: wait for next detected hs_n falling edge -> PAD, load pad_target = PAD_x_LINES, line_cnt=0, pad_cnt=0.
- PAD: vdg_clk_en=0, pad_active=1. line_cnt counts 0..LINE_CLKS-1 and wraps; pad_cnt increments on wrap. hs_out=0 when line_cnt<HS_CLKS, else 1. Period 0 starts on the freeze edge, so the generated pulse continues the VDG pulse seamlessly.
- Exit: at line_cnt=LINE_CLKS-1 and pad_cnt=pad_target-1 -> PASS (or directly to ARM of a pending request). VDG resumes at the frozen sync start; exactly pad_target lines are inserted.
- Simultaneous/overlapping events: an fs_n edge detected during ARM or PAD sets a pending flag for that block (A or B); it is served on exit in arrival order. A second edge of the same type while its flag is already set is dropped.
- pal_en: sampled only in PASS. Deassertion during ARM/PAD does not abort; the current block completes and pending flags clear.
- Arithmetic: line_cnt width clog2(LINE_CLKS); pad_cnt width clog2(max(PAD_A_LINES,PAD_B_LINES)+1); no overflow past target.
- rst mid-PAD: next cycle vdg_clk_en=1, hs_out=1, state PASS, pending flags lost.

## Timing
- Edge-detect latency, input change to state/hs_out reaction: 3 clk with PAL_SCHED_SYNC_EN, 1 clk without.
- vdg_clk_en falls in the same cycle the state enters PAD. It rises the cycle after the final line_cnt=LINE_CLKS-1.
- Total freeze per block: exactly pad_target×LINE_CLKS cycles.
- All outputs registered; no combinational input-to-output path.

## Configuration
- PAL_SCHED_SYNC_EN defined: hs_n and fs_n pass through 2-flop synchronisers before edge detection (inputs may be asynchronous, e.g. divided VDG clock domain).
- Undefined: inputs are treated as synchronous to clk; single register for edge detection only; latency 1 clk.

## Structure
- Package pal_sched_pkg: state encoding constants (PASS, ARM_A, ARM_B, PAD), default LINE_CLKS/HS_CLKS/PAD line counts.
- Sub-module sync_edge_det: optional synchroniser plus rise/fall pulse outputs, instantiated for hs_n and fs_n.

## Test plan
- Reset mid-PAD (pad_cnt=10) -> next cycle vdg_clk_en=1, hs_out=1, pad_active=0; no pad until next fs_n edge.
- pal_en=1, fs_n fall then hs_n fall -> vdg_clk_en low for exactly 25×912=22800 clk; 25 hs_out pulses each 67 clk wide, 912 clk apart.
- fs_n rise while PAD_A is in progress -> PAD_B starts immediately after PAD_A exit (ARM_B, next hs_n fall); total 50 lines per field.
- pal_en=0 across full field -> vdg_clk_en constantly 1; hs_out equals hs_n delayed by 3 (sync on) / 1 (sync off) clk.
- PAD_B_LINES=0 -> fs_n rise ignored; only the 25-line A block is inserted.
- pal_en dropped in PAD_A with pending B -> A completes 25 lines, B is discarded, state returns to PASS.
